mul_cla_pipe_adder: RTL
=======================

Name: mul_cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the FPU_MUL datapath. Generalises the fixed 24-bit nibble-CLA adder to configurable width, group size and pipeline depth.
- Adds add/sub mode, signed-overflow and zero flags, and a valid/ready handshake so it sits in the stall-capable multiplier pipeline, e.g. mantissa rounding and exponent adjust.

Parameters:
- WIDTH, 24, operand/sum width in bits.
- GROUP, 4, bits per CLA group; group P/G are combined with full lookahead inside a stage.
- STAGES, 2, pipeline stages. Each stage adds SEG = WIDTH/STAGES bits. Required: WIDTH % (GROUP*STAGES) == 0 and STAGES >= 1; violation is an elaboration-time error.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream operand valid.
- o_ready  output  1  block accepts operands this cycle.
- i_sub  input  1  0: a+b+i_carry; 1: a-b (a + ~b + 1).
- i_carry  input  1  carry-in for add mode; ignored when i_sub=1.
- i_data_a  input  WIDTH  operand A.
- i_data_b  input  WIDTH  operand B.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_sum  output  WIDTH  result modulo 2^WIDTH.
- o_carry  output  1  carry out of MSB (sub mode: 1 = no borrow).
- o_overflow  output  1  two's-complement signed overflow.
- o_zero  output  1  o_sum == 0.

Behaviour:
- Reset (async assert, sync deassert handled upstream): all stage valid bits, o_valid, o_sum, o_carry, o_overflow and o_zero are 0. All in-flight operations are discarded. No output appears for any operation accepted before reset.
- Global stall enable: en = ~o_valid | i_ready. o_ready = en, combinational, no dependence on i_valid.
- An operation is accepted when i_valid & o_ready. All pipeline registers, including valid bits, load only when en=1.
- Latency: exactly STAGES cycles from the accept edge to o_valid=1 when no stall occurs. Throughput: 1 op/cycle.
- Stage k (0..STAGES-1) computes bits [k*SEG +: SEG]:
  - Carry-in is the registered carry from stage k-1. Stage 0 uses cin = i_sub ? 1 : i_carry.
  - B slice is inverted when the op's sub bit is set.
  - Within a stage, GROUP-bit P/G are formed and group carries come from a full lookahead across the stage's groups, not a ripple.
- Skew registers: operand slices for later stages and computed sum slices for earlier stages are delayed so all WIDTH bits of one op reach the output register together. The sub bit and the operand MSBs travel with the op.
- Flags:
  - o_carry = carry out of bit WIDTH-1.
  - o_overflow = carry into MSB XOR carry out of MSB (equivalently sign rule on a, effective b, sum).
  - o_zero = ~|o_sum.
  - All flags update with o_sum.
- Output hold: while o_valid=1 and i_ready=0, o_sum/o_carry/o_overflow/o_zero/o_valid hold stable and no new op is accepted.
- Bubbles: with global stall, a bubble (valid=0) inside the pipe is not collapsed during a stall. Order is always preserved.
- When o_valid=0, data outputs hold their last value. Bench checks data only when o_valid=1.
- Simultaneous accept and output handshake in the same cycle is legal: the pipe advances one slot.
- STAGES=1 degenerates to a single registered full-width CLA with latency 1.

Test Plan:
- WIDTH=24, STAGES=2, i_ready=1. Add 0xFFFFFF + 0x000001, i_carry=0 -> after 2 cycles o_sum=0x000000, o_carry=1, o_zero=1, o_overflow=0.
- Stage-boundary carry: 0x000FFF + 0x000001 -> 0x001000, o_carry=0. Also 0x000FFF + 0x000000 with i_carry=1 -> 0x001000.
- Sub: 0x000005 - 0x000007, i_carry=1 (ignored) -> o_sum=0xFFFFFE, o_carry=0, o_overflow=0. Then 0x800000 - 0x000001 -> 0x7FFFFF, o_overflow=1, o_carry=1.
- Signed overflow add: 0x7FFFFF + 0x000001 -> 0x800000, o_overflow=1, o_carry=0.
- Backpressure: stream 4 back-to-back ops and drop i_ready for 3 cycles once o_valid=1 -> o_ready=0 during the stall, outputs frozen, all 4 results delivered in order, none duplicated or lost.
- Reset mid-flight: accept 2 ops, assert i_rst one cycle later -> o_valid=0 immediately (async) and stays 0. The next op accepted after release appears after exactly 2 cycles. Repeat with STAGES=1 and with WIDTH=32, GROUP=4, STAGES=4, checking random ops against a+b+cin with latency 1 and 4 respectively.

Source files
------------

// File: rtl/mul_cla_pipe_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// The upstream side drives operands and the downstream side drives i_ready.
interface mul_cla_pipe_adder_if #(
  parameter int WIDTH = 24
);
  logic             i_valid;
  logic             o_ready;
  logic             i_sub;
  logic             i_carry;
  logic [WIDTH-1:0] i_data_a;
  logic [WIDTH-1:0] i_data_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_overflow;
  logic             o_zero;

  modport master (
    output i_valid, i_sub, i_carry, i_data_a, i_data_b, i_ready,
    input  o_ready, o_valid, o_sum, o_carry, o_overflow, o_zero
  );

  modport slave (
    input  i_valid, i_sub, i_carry, i_data_a, i_data_b, i_ready,
    output o_ready, o_valid, o_sum, o_carry, o_overflow, o_zero
  );
endinterface

// File: rtl/mul_cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with a global stall enable.
// Each stage adds one SEG-bit slice; operand and sum slices are skewed so an op leaves whole.
module mul_cla_pipe_adder #(
  parameter int WIDTH  = 24,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mul_cla_pipe_adder_if.slave bus
);
  localparam int SEG = WIDTH / ((STAGES < 1) ? 1 : STAGES);
  localparam int NG  = SEG / ((GROUP < 1) ? 1 : GROUP);

  if ((STAGES < 1) || (GROUP < 1) ? 1'b1 : ((WIDTH % (GROUP * STAGES)) != 0)) begin : g_bad_cfg
    $error("mul_cla_pipe_adder: WIDTH must be a multiple of GROUP*STAGES and STAGES >= 1");
  end

  // Returns {carry_out, sum}; group carries are flattened sum-of-products, not a ripple.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           cin);
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG-1:0] c;
    logic [NG-1:0]  gp;
    logic [NG-1:0]  gg;
    logic [NG:0]    gc;
    logic           t;
    p = a ^ b;
    g = a & b;
    for (int n = 0; n < NG; n++) begin
      gp[n] = 1'b1;
      gg[n] = 1'b0;
      for (int i = GROUP - 1; i >= 0; i--) begin
        gg[n] = gg[n] | (g[n*GROUP+i] & gp[n]);
        gp[n] = gp[n] & p[n*GROUP+i];
      end
    end
    gc[0] = cin;
    for (int n = 1; n <= NG; n++) begin
      gc[n] = 1'b0;
      t     = 1'b1;
      for (int j = n - 1; j >= 0; j--) begin
        gc[n] = gc[n] | (gg[j] & t);
        t     = t & gp[j];
      end
      gc[n] = gc[n] | (cin & t);
    end
    for (int n = 0; n < NG; n++) begin
      c[n*GROUP] = gc[n];
      for (int i = 1; i < GROUP; i++) begin
        c[n*GROUP+i] = g[n*GROUP+i-1] | (p[n*GROUP+i-1] & c[n*GROUP+i-1]);
      end
    end
    return {gc[NG], p ^ c};
  endfunction

  logic en_s;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]    a_in_s;
    logic [REM-1:0]    b_in_s;
    logic              sub_in_s;
    logic              cin_s;
    logic              vld_in_s;
    logic [SEG-1:0]    b_eff_s;
    logic [SEG:0]      res_s;
    logic [LO+SEG-1:0] sum_nxt_s;
    logic              vld_r;
    logic              carry_r;
    logic [LO+SEG-1:0] sum_r;

    if (k == 0) begin : g_src
      assign a_in_s    = bus.i_data_a;
      assign b_in_s    = bus.i_data_b;
      assign sub_in_s  = bus.i_sub;
      assign cin_s     = bus.i_sub | bus.i_carry;
      assign vld_in_s  = bus.i_valid;
      assign sum_nxt_s = res_s[SEG-1:0];
    end else begin : g_src
      assign a_in_s    = stg[k-1].g_fwd.a_r;
      assign b_in_s    = stg[k-1].g_fwd.b_r;
      assign sub_in_s  = stg[k-1].g_fwd.sub_r;
      assign cin_s     = stg[k-1].carry_r;
      assign vld_in_s  = stg[k-1].vld_r;
      assign sum_nxt_s = {res_s[SEG-1:0], stg[k-1].sum_r};
    end

    assign b_eff_s = b_in_s[SEG-1:0] ^ {SEG{sub_in_s}};
    assign res_s   = cla_seg(a_in_s[SEG-1:0], b_eff_s, cin_s);

    // Stage result register; valid advances on every enabled edge so bubbles keep their slot
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        vld_r   <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= '0;
      end else if (en_s) begin
        vld_r <= vld_in_s;
        if (vld_in_s) begin
          carry_r <= res_s[SEG];
          sum_r   <= sum_nxt_s;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SEG-1:0] a_r;
      logic [REM-SEG-1:0] b_r;
      logic               sub_r;

      // Upper operand slices and the mode bit wait here for their stage
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          a_r   <= '0;
          b_r   <= '0;
          sub_r <= 1'b0;
        end else if (en_s && vld_in_s) begin
          a_r   <= a_in_s[REM-1:SEG];
          b_r   <= b_in_s[REM-1:SEG];
          sub_r <= sub_in_s;
        end
      end
    end else begin : g_last
      logic ovf_r;
      logic zero_r;

      // Flags are registered alongside the final sum; MSB carry-in is recovered as a^b^sum
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          ovf_r  <= 1'b0;
          zero_r <= 1'b0;
        end else if (en_s && vld_in_s) begin
          ovf_r  <= a_in_s[SEG-1] ^ b_eff_s[SEG-1] ^ res_s[SEG-1] ^ res_s[SEG];
          zero_r <= ~|sum_nxt_s;
        end
      end
    end
  end

  assign en_s           = ~stg[STAGES-1].vld_r | bus.i_ready;
  assign bus.o_ready    = en_s;
  assign bus.o_valid    = stg[STAGES-1].vld_r;
  assign bus.o_sum      = stg[STAGES-1].sum_r;
  assign bus.o_carry    = stg[STAGES-1].carry_r;
  assign bus.o_overflow = stg[STAGES-1].g_last.ovf_r;
  assign bus.o_zero     = stg[STAGES-1].g_last.zero_r;
endmodule
